// File: rtl/alu_result_monitor.sv
// alu_result_monitor: FIFO capture of ALU result/flag samples with saturating drop and flag counters.
// Define FLAG_STATS_EN to build the four flag event counters; otherwise they read 0.
module alu_result_monitor #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_result,
  input  logic [3:0]               i_flag,
  output logic                     o_ready,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [WIDTH-1:0]         o_rd_result,
  output logic [3:0]               o_rd_flag,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [CNT_WIDTH-1:0]     o_drop_cnt,
  output logic [CNT_WIDTH-1:0]     o_cnt_err,
  output logic [CNT_WIDTH-1:0]     o_cnt_neg,
  output logic [CNT_WIDTH-1:0]     o_cnt_pos,
  output logic [CNT_WIDTH-1:0]     o_cnt_ovf
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
  state_t state, state_nxt;
  logic [WIDTH+3:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, count_nxt;
  logic push, pop, drop;
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
    return (en && !(&c)) ? c + CNT_WIDTH'(1) : c;
  endfunction
  assign o_full = state == FULL;
  assign o_empty = state == EMPTY;
  assign o_ready = !o_full;
  assign o_rd_valid = !o_empty;
  assign o_count = count;
  assign push = i_valid && o_ready;
  assign pop = o_rd_valid && i_rd_ready;
  assign drop = i_valid && o_full;
  assign o_rd_result = o_rd_valid ? mem[rptr][WIDTH-1:0] : '0;
  assign o_rd_flag = o_rd_valid ? mem[rptr][WIDTH+3:WIDTH] : '0;
  always_comb begin
    count_nxt = (push && !pop) ? count + (AW+1)'(1) : (pop && !push) ? count - (AW+1)'(1) : count;
    state_nxt = (count_nxt == '0) ? EMPTY : (count_nxt == (AW+1)'(DEPTH)) ? FULL : PARTIAL;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= EMPTY;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      o_drop_cnt <= '0;
    end else if (i_clear) begin
      state <= EMPTY;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      o_drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      o_drop_cnt <= sat_inc(o_drop_cnt, drop);
    end
  // storage needs no reset: the read port is gated by o_rd_valid
  always_ff @(posedge i_clk)
    if (push && !i_clear) mem[wptr] <= {i_flag, i_result};
`ifdef FLAG_STATS_EN
  logic [CNT_WIDTH-1:0] flag_cnt [4];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int i = 0; i < 4; i++) flag_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) flag_cnt[i] <= i_clear ? '0 : sat_inc(flag_cnt[i], push && i_flag[i]);
    end
  assign o_cnt_err = flag_cnt[0];
  assign o_cnt_neg = flag_cnt[1];
  assign o_cnt_pos = flag_cnt[2];
  assign o_cnt_ovf = flag_cnt[3];
`else
  assign o_cnt_err = '0;
  assign o_cnt_neg = '0;
  assign o_cnt_pos = '0;
  assign o_cnt_ovf = '0;
`endif
endmodule

// File: tb/tb_alu_result_monitor.sv
// tb_alu_result_monitor: directed checks of capture FIFO, drop/flag counters, clear and async reset.
module tb_alu_result_monitor;
  logic i_clk = 0, i_rst = 1, i_clear = 0, i_valid = 0, i_rd_ready = 0;
  logic [3:0] i_result = 0, i_flag = 0;
  logic o_ready, o_rd_valid, o_full, o_empty;
  logic [3:0] o_rd_result, o_rd_flag, o_drop_cnt, o_cnt_err, o_cnt_neg, o_cnt_pos, o_cnt_ovf;
  logic [3:0] o_count;
  int cmps = 0, errs = 0;
  logic [3:0] q [$];
`ifdef FLAG_STATS_EN
  localparam bit STATS = 1;
`else
  localparam bit STATS = 0;
`endif
  alu_result_monitor #(.WIDTH(4), .DEPTH(8), .CNT_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid),
    .i_result(i_result), .i_flag(i_flag), .o_ready(o_ready), .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready), .o_rd_result(o_rd_result), .o_rd_flag(o_rd_flag),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_drop_cnt(o_drop_cnt),
    .o_cnt_err(o_cnt_err), .o_cnt_neg(o_cnt_neg), .o_cnt_pos(o_cnt_pos), .o_cnt_ovf(o_cnt_ovf)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_flags(input string tag, input int e, input int n, input int p, input int o);
    chk({tag, "_err"}, o_cnt_err, st(e));
    chk({tag, "_neg"}, o_cnt_neg, st(n));
    chk({tag, "_pos"}, o_cnt_pos, st(p));
    chk({tag, "_ovf"}, o_cnt_ovf, st(o));
  endtask
  task automatic do_clear();
    i_clear = 1;
    tick();
    i_clear = 0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", o_ready, 1);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_count", o_count, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_rd_result", o_rd_result, 0);
    chk("rst_rd_flag", o_rd_flag, 0);
    chk_flags("rst", 0, 0, 0, 0);
    i_rst = 0;
    tick();
    // basic write: result 2, flag pos
    i_valid = 1; i_result = 4'd2; i_flag = 4'b0100;
    tick();
    i_valid = 0;
    chk("basic_rd_valid", o_rd_valid, 1);
    chk("basic_rd_result", o_rd_result, 2);
    chk("basic_rd_flag", o_rd_flag, 4'b0100);
    chk("basic_count", o_count, 1);
    chk_flags("basic", 0, 0, 1, 0);
    i_rd_ready = 1;
    tick();
    i_rd_ready = 0;
    chk("basic_pop_empty", o_empty, 1);
    chk("basic_pop_rd_result", o_rd_result, 0);
    // fill and drop: ten writes into an eight-entry FIFO
    for (int k = 0; k < 10; k++) begin
      i_valid = 1; i_result = 4'(k); i_flag = 4'b0001;
      tick();
      if (k == 6) chk("fill_not_full7", o_full, 0);
      if (k == 7) chk("fill_full8", o_full, 1);
    end
    i_valid = 0;
    chk("fill_drop", o_drop_cnt, 2);
    chk("fill_count", o_count, 8);
    chk("fill_ready", o_ready, 0);
    chk_flags("fill", 8, 0, 1, 0);
    i_rd_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", o_rd_result, 4'(k));
      chk("drain_flag", o_rd_flag, 4'b0001);
      tick();
    end
    i_rd_ready = 0;
    chk("drain_empty", o_empty, 1);
    chk("drain_count", o_count, 0);
    // wrap and concurrency at occupancy 3
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; i_result = 4'(10 + k); i_flag = 0;
      q.push_back(4'(10 + k));
      tick();
    end
    chk("wrap_pre_count", o_count, 3);
    i_rd_ready = 1;
    for (int j = 0; j < 20; j++) begin
      i_result = 4'(j * 5 + 1);
      chk("wrap_head", o_rd_result, q[0]);
      void'(q.pop_front());
      q.push_back(4'(j * 5 + 1));
      tick();
      chk("wrap_count", o_count, 3);
    end
    i_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("wrap_tail", o_rd_result, q[0]);
      void'(q.pop_front());
      tick();
    end
    i_rd_ready = 0;
    chk("wrap_empty", o_empty, 1);
    // full plus simultaneous pop: sample dropped, head popped
    for (int k = 0; k < 8; k++) begin
      i_valid = 1; i_result = 4'(8 - k); i_flag = 0;
      tick();
    end
    chk("fp_full", o_full, 1);
    chk("fp_head_before", o_rd_result, 8);
    i_result = 4'hF; i_rd_ready = 1;
    tick();
    i_valid = 0; i_rd_ready = 0;
    chk("fp_count", o_count, 7);
    chk("fp_drop", o_drop_cnt, 3);
    chk("fp_full_after", o_full, 0);
    chk("fp_head_after", o_rd_result, 7);
    // saturation of flag counters with concurrent drain
    do_clear();
    chk("clr_count", o_count, 0);
    chk("clr_drop", o_drop_cnt, 0);
    chk_flags("clr", 0, 0, 0, 0);
    i_rd_ready = 1;
    for (int k = 0; k < 20; k++) begin
      i_valid = 1; i_result = 4'(k); i_flag = 4'b1010;
      tick();
    end
    i_valid = 0;
    chk("sat_drop", o_drop_cnt, 0);
    chk("sat_count", o_count, 1);
    chk_flags("sat", 0, 15, 0, 15);
    // clear wins over a concurrent write
    i_valid = 1; i_clear = 1;
    tick();
    i_valid = 0; i_clear = 0; i_rd_ready = 0;
    chk("clrw_count", o_count, 0);
    chk("clrw_empty", o_empty, 1);
    chk_flags("clrw", 0, 0, 0, 0);
    // drop counter saturation
    for (int k = 0; k < 28; k++) begin
      i_valid = 1; i_result = 4'(k); i_flag = 0;
      tick();
    end
    i_valid = 0;
    chk("dsat_drop", o_drop_cnt, 15);
    chk("dsat_count", o_count, 8);
    do_clear();
    chk("dsat_clr_drop", o_drop_cnt, 0);
    // async reset with five entries queued
    for (int k = 0; k < 5; k++) begin
      i_valid = 1; i_result = 4'(k + 3); i_flag = 4'b1111;
      tick();
    end
    i_valid = 0;
    chk("ar_pre_count", o_count, 5);
    chk_flags("ar_pre", 5, 5, 5, 5);
    #2;
    i_rst = 1;
    #1;
    chk("ar_empty", o_empty, 1);
    chk("ar_rd_valid", o_rd_valid, 0);
    chk("ar_count", o_count, 0);
    chk("ar_rd_result", o_rd_result, 0);
    chk_flags("ar", 0, 0, 0, 0);
    tick();
    i_rst = 0;
    tick();
    chk("ar_post_empty", o_empty, 1);
    chk("ar_post_ready", o_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
